ntsc_timing_generator: RTL

//  Free-running NTSC raster timer clocked at 16x colour subcarrier (57.272727 MHz).

---
 rtl/ntsc_timing_pkg.sv | 59 +++++
 rtl/ntsc_timing_generator_if.sv | 26 ++
 rtl/ntsc_vertical_sequencer.sv | 71 +++++++
 rtl/ntsc_timing_generator.sv | 117 +++++++++++
 4 files changed

// File: rtl/ntsc_timing_pkg.sv
// ntsc_timing_pkg
//   Default NTSC raster constants, the vertical line-state enum and the
//   registered output bundle shared by the timing generator and its
//   vertical sequencer. Future interlaced/PAL variants reuse the enum and
//   override the constants through module parameters.
package ntsc_timing_pkg;

  localparam int CLOCKS_PER_LINE_DEF   = 3640;
  localparam int HSYNC_WIDTH_DEF       = 269;
  localparam int EQ_WIDTH_DEF          = 132;
  localparam int SERRATION_WIDTH_DEF   = 269;
  localparam int BURST_START_DEF       = 303;
  localparam int BURST_WIDTH_DEF       = 144;
  localparam int ACTIVE_START_DEF      = 624;
  localparam int ACTIVE_END_DEF        = 3554;
  localparam int LINES_PER_FRAME_DEF   = 262;
  localparam int VSYNC_FIRST_LINE_DEF  = 3;
  localparam int ACTIVE_FIRST_LINE_DEF = 21;
  localparam int ACTIVE_LAST_LINE_DEF  = 260;

  typedef enum logic [2:0] {
    PRE_EQ,
    VSYNC,
    POST_EQ,
    VBLANK,
    ACTIVE
  } line_state_e;

  // One registered sample of every timing output.
  typedef struct packed {
    logic [3:0]  phase;
    logic        blank;
    logic        sync;
    logic        burst;
    logic [11:0] h_count;
    logic [8:0]  v_count;
    logic        line_start;
    logic        frame_start;
  } timing_out_t;

  localparam timing_out_t TIMING_OUT_RESET = '{
    phase:       4'd0,
    blank:       1'b1,
    sync:        1'b0,
    burst:       1'b0,
    h_count:     12'd0,
    v_count:     9'd0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  // Half-open window test: lo <= x < hi.
  function automatic logic in_range(input logic [11:0] x,
                                    input logic [11:0] lo,
                                    input logic [11:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/ntsc_timing_generator_if.sv
// ntsc_timing_generator_if
//   Timing outputs of the raster generator.
//   master: driven by the generator; slave: DAC sample generator / pixel source.
//   subcarrierPhase[3:0]  phase of the 16x subcarrier
//   blank, sync, burst    composite level controls
//   hCount[11:0]          clock index within the line
//   vCount[8:0]           line index within the frame
//   lineStart/frameStart  1-cycle strobes at hCount==0 (and vCount==0)
interface ntsc_timing_generator_if;
  logic [3:0]  subcarrierPhase;
  logic        blank;
  logic        sync;
  logic        burst;
  logic [11:0] hCount;
  logic [8:0]  vCount;
  logic        lineStart;
  logic        frameStart;

  modport master (
    output subcarrierPhase, blank, sync, burst, hCount, vCount, lineStart, frameStart
  );

  modport slave (
    input subcarrierPhase, blank, sync, burst, hCount, vCount, lineStart, frameStart
  );
endinterface

// File: rtl/ntsc_vertical_sequencer.sv
// ntsc_vertical_sequencer
//   Line counter and vertical line-state FSM. Both advance only on the
//   line-wrap strobe from the horizontal counter.
//   clk_i        16x subcarrier clock
//   rst_n_i      synchronous active-low reset
//   line_wrap_i  high on the last clock of a line
//   v_count_o    current line index
//   state_o      current line state
module ntsc_vertical_sequencer
  import ntsc_timing_pkg::*;
#(
  parameter int LINES_PER_FRAME   = LINES_PER_FRAME_DEF,
  parameter int VSYNC_FIRST_LINE  = VSYNC_FIRST_LINE_DEF,
  parameter int ACTIVE_FIRST_LINE = ACTIVE_FIRST_LINE_DEF,
  parameter int ACTIVE_LAST_LINE  = ACTIVE_LAST_LINE_DEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        line_wrap_i,
  output logic [8:0]  v_count_o,
  output line_state_e state_o
);

  // Last line of each state; 3 eq lines either side of 3 vsync lines.
  localparam logic [8:0] V_LAST       = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] PRE_EQ_LAST  = 9'(VSYNC_FIRST_LINE - 1);
  localparam logic [8:0] VSYNC_LAST   = 9'(VSYNC_FIRST_LINE + 2);
  localparam logic [8:0] POST_EQ_LAST = 9'(VSYNC_FIRST_LINE + 5);
  localparam logic [8:0] VBLANK_LAST  = 9'(ACTIVE_FIRST_LINE - 1);
  localparam logic [8:0] ACTIVE_LAST  = 9'(ACTIVE_LAST_LINE);

  logic [8:0]  v_q, v_d;
  line_state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      v_q     <= '0;
      state_q <= PRE_EQ;
    end else begin
      v_q     <= v_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    v_d     = v_q;
    state_d = state_q;
    if (line_wrap_i) begin
      v_d = (v_q == V_LAST) ? 9'd0 : v_q + 9'd1;
      case (state_q)
        PRE_EQ:  if (v_q == PRE_EQ_LAST)  state_d = VSYNC;
        VSYNC:   if (v_q == VSYNC_LAST)   state_d = POST_EQ;
        POST_EQ: if (v_q == POST_EQ_LAST) state_d = VBLANK;
        // VBLANK occurs twice per frame: before active video and at frame end.
        VBLANK: begin
          if (v_q == V_LAST)           state_d = PRE_EQ;
          else if (v_q == VBLANK_LAST) state_d = ACTIVE;
        end
        ACTIVE: begin
          if (v_q == V_LAST)           state_d = PRE_EQ;
          else if (v_q == ACTIVE_LAST) state_d = VBLANK;
        end
        default: state_d = PRE_EQ;
      endcase
    end
  end

  assign v_count_o = v_q;
  assign state_o   = state_q;

endmodule

// File: rtl/ntsc_timing_generator.sv
// ntsc_timing_generator
//   Free-running progressive NTSC raster timer at 16x subcarrier.
//   phaseClock_i  16x subcarrier clock (only clock)
//   reset_i       synchronous active-low reset
//   timing_o      master side of the timing interface (phase, blank, sync,
//                 burst, hCount, vCount, lineStart, frameStart)
//   The horizontal and phase counters run one clock ahead of the outputs;
//   every output is decoded from those counters and registered together, so
//   all outputs describe the same clock with no mutual skew.
module ntsc_timing_generator
  import ntsc_timing_pkg::*;
#(
  parameter int CLOCKS_PER_LINE   = CLOCKS_PER_LINE_DEF,
  parameter int HSYNC_WIDTH       = HSYNC_WIDTH_DEF,
  parameter int EQ_WIDTH          = EQ_WIDTH_DEF,
  parameter int SERRATION_WIDTH   = SERRATION_WIDTH_DEF,
  parameter int BURST_START       = BURST_START_DEF,
  parameter int BURST_WIDTH       = BURST_WIDTH_DEF,
  parameter int ACTIVE_START      = ACTIVE_START_DEF,
  parameter int ACTIVE_END        = ACTIVE_END_DEF,
  parameter int LINES_PER_FRAME   = LINES_PER_FRAME_DEF,
  parameter int VSYNC_FIRST_LINE  = VSYNC_FIRST_LINE_DEF,
  parameter int ACTIVE_FIRST_LINE = ACTIVE_FIRST_LINE_DEF,
  parameter int ACTIVE_LAST_LINE  = ACTIVE_LAST_LINE_DEF
) (
  input  logic                     phaseClock_i,
  input  logic                     reset_i,
  ntsc_timing_generator_if.master  timing_o
);

  localparam logic [11:0] H_LAST   = 12'(CLOCKS_PER_LINE - 1);
  localparam logic [11:0] H_HALF   = 12'(CLOCKS_PER_LINE / 2);
  localparam logic [11:0] EQ_END   = 12'(EQ_WIDTH);
  localparam logic [11:0] EQ2_END  = 12'(CLOCKS_PER_LINE / 2 + EQ_WIDTH);
  // Vsync lines hold sync except for the serration at the end of each half.
  localparam logic [11:0] VS1_END  = 12'(CLOCKS_PER_LINE / 2 - SERRATION_WIDTH);
  localparam logic [11:0] VS2_END  = 12'(CLOCKS_PER_LINE - SERRATION_WIDTH);
  localparam logic [11:0] HS_END   = 12'(HSYNC_WIDTH);
  localparam logic [11:0] BU_START = 12'(BURST_START);
  localparam logic [11:0] BU_END   = 12'(BURST_START + BURST_WIDTH);
  localparam logic [11:0] AV_START = 12'(ACTIVE_START);
  localparam logic [11:0] AV_END   = 12'(ACTIVE_END);

  logic [11:0] h_q, h_d;
  logic [3:0]  ph_q;
  logic        line_wrap;
  logic [8:0]  v_cnt;
  line_state_e v_state;
  logic        sync_c, burst_c, active_c;
  timing_out_t out_q, out_d;

  assign line_wrap = (h_q == H_LAST);
  assign h_d       = line_wrap ? 12'd0 : h_q + 12'd1;

  ntsc_vertical_sequencer #(
    .LINES_PER_FRAME   (LINES_PER_FRAME),
    .VSYNC_FIRST_LINE  (VSYNC_FIRST_LINE),
    .ACTIVE_FIRST_LINE (ACTIVE_FIRST_LINE),
    .ACTIVE_LAST_LINE  (ACTIVE_LAST_LINE)
  ) u_vseq (
    .clk_i       (phaseClock_i),
    .rst_n_i     (reset_i),
    .line_wrap_i (line_wrap),
    .v_count_o   (v_cnt),
    .state_o     (v_state)
  );

  always_comb begin
    sync_c   = 1'b0;
    burst_c  = 1'b0;
    case (v_state)
      PRE_EQ, POST_EQ: sync_c = (h_q < EQ_END) || in_range(h_q, H_HALF, EQ2_END);
      VSYNC:           sync_c = (h_q < VS1_END) || in_range(h_q, H_HALF, VS2_END);
      VBLANK, ACTIVE: begin
        sync_c  = (h_q < HS_END);
        burst_c = in_range(h_q, BU_START, BU_END);
      end
      default: ;
    endcase
    active_c = (v_state == ACTIVE) && in_range(h_q, AV_START, AV_END);

    out_d             = TIMING_OUT_RESET;
    out_d.phase       = ph_q;
    out_d.sync        = sync_c;
    out_d.burst       = burst_c;
    // Force blank under sync/burst even if the windows are mis-set.
    out_d.blank       = !active_c || sync_c || burst_c;
    out_d.h_count     = h_q;
    out_d.v_count     = v_cnt;
    out_d.line_start  = (h_q == 12'd0);
    out_d.frame_start = (h_q == 12'd0) && (v_cnt == 9'd0);
  end

  // Phase is never reloaded outside reset; an even line count with
  // CLOCKS_PER_LINE = 8 mod 16 gives 0/8 alternation at line start.
  always_ff @(posedge phaseClock_i) begin
    if (!reset_i) begin
      h_q   <= '0;
      ph_q  <= '0;
      out_q <= TIMING_OUT_RESET;
    end else begin
      h_q   <= h_d;
      ph_q  <= ph_q + 4'd1;
      out_q <= out_d;
    end
  end

  assign timing_o.subcarrierPhase = out_q.phase;
  assign timing_o.blank           = out_q.blank;
  assign timing_o.sync            = out_q.sync;
  assign timing_o.burst           = out_q.burst;
  assign timing_o.hCount          = out_q.h_count;
  assign timing_o.vCount          = out_q.v_count;
  assign timing_o.lineStart       = out_q.line_start;
  assign timing_o.frameStart      = out_q.frame_start;

endmodule
